// File: rtl/tx_pulse_shaper_pkg.sv
// Shared constants for the TX pulse shaper: PRBS9 geometry, symbol map, default RRC taps.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_pulse_shaper_pkg;

  // PRBS9 x^9 + x^5 + 1, Fibonacci form: output is the MSB, feedback from bits 8 and 4.
  localparam int PRBS9_LEN   = 9;
  localparam int PRBS9_TAP_A = 8;
  localparam int PRBS9_TAP_B = 4;

  typedef logic [PRBS9_LEN-1:0] prbs9_t;

  // Symbol map: a 0 bit is +1, a 1 bit is -1, matching the RX slicer sign.
  localparam logic SYM_BIT_NEG = 1'b1;

  // Default geometry.
  localparam int DEF_OS       = 4;
  localparam int DEF_NBAUD    = 6;
  localparam int DEF_NBT_COEF = 8;
  localparam int DEF_NBF_COEF = 7;
  localparam int DEF_NBT_OUT  = 8;
  localparam int DEF_NBF_OUT  = 7;

  // Root-raised-cosine, rolloff 0.5, 4 samples/symbol, 6-symbol span, Q1.7.
  // Tap n sits at bits [(n+1)*8-1 -: 8]; the leftmost byte is tap 23, the rightmost tap 0.
  // Main lobe peaks at tap 12 (0x60); the taps are the RRC sampled at t = (n-12)/4 symbols.
  localparam logic [DEF_OS*DEF_NBAUD*DEF_NBT_COEF-1:0] DEF_RRC_COEFS =
    192'hFFFF_0104_01FA_F3F7_0D31_5260_5231_0DF7_F3FA_0104_01FF_FF00;

  // One PRBS9 step: shift left, feed back r[8]^r[4] into the LSB.
  function automatic prbs9_t prbs9_next(input prbs9_t r);
    prbs9_next = {r[PRBS9_LEN-2:0], r[PRBS9_TAP_A] ^ r[PRBS9_TAP_B]};
  endfunction

endpackage

// File: rtl/tx_pulse_shaper_if.sv
// Sample-stream bundle between the pulse shaper and its consumer (channel model / BER checker).
// Latency: n/a (wires only).
// Backpressure: none; the only control is the enable driven by the consumer side.
interface tx_pulse_shaper_if #(
  parameter int OS      = 4,
  parameter int NBT_OUT = 8
);

  localparam int NB_PH = (OS > 1) ? $clog2(OS) : 1;

  logic                      i_en_tx;
  logic signed [NBT_OUT-1:0] o_os_data_I;
  logic signed [NBT_OUT-1:0] o_os_data_Q;
  logic                      o_bit_I;
  logic                      o_bit_Q;
  logic                      o_sym_strobe;
  logic [NB_PH-1:0]          o_phase;

  // The shaper is the source of the sample stream.
  modport master (
    input  i_en_tx,
    output o_os_data_I, o_os_data_Q, o_bit_I, o_bit_Q, o_sym_strobe, o_phase
  );

  // The consumer gates the shaper and receives its samples.
  modport slave (
    output i_en_tx,
    input  o_os_data_I, o_os_data_Q, o_bit_I, o_bit_Q, o_sym_strobe, o_phase
  );

endinterface

// File: rtl/tx_pulse_shaper_prbs9_gen.sv
// PRBS9 bit source (x^9+x^5+1), advances one step per enabled cycle, output is register MSB.
// Latency: o_bit is combinational from the state register; new bit visible the cycle after i_en.
// Backpressure: i_en low holds the state; nothing is lost or repeated.
module tx_pulse_shaper_prbs9_gen
  import tx_pulse_shaper_pkg::*;
#(
  parameter prbs9_t SEED = 9'h1AA
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_bit
);

  // An all-zero seed locks the LFSR at zero forever.
  if (SEED == '0) begin : g_seed_check
    $error("tx_pulse_shaper_prbs9_gen: SEED must be nonzero");
  end

  prbs9_t r;

  // LFSR state: reload the seed on reset, otherwise step when enabled.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r <= SEED;
    end else if (i_en) begin
      r <= prbs9_next(r);
    end
  end

  assign o_bit = r[PRBS9_LEN-1];

endmodule

// File: rtl/tx_pulse_shaper.sv
// PRBS9 I/Q symbols shaped by a polyphase FIR, OS samples per symbol, NBAUD-symbol span.
// Latency: 1 clk from the phase register/symbol slots to o_os_data_*.
// Backpressure: i_en_tx low freezes every register; the stream resumes without skip or repeat.
module tx_pulse_shaper
  import tx_pulse_shaper_pkg::*;
#(
  parameter int     OS       = DEF_OS,
  parameter int     NBAUD    = DEF_NBAUD,
  parameter int     NBT_COEF = DEF_NBT_COEF,
  parameter int     NBF_COEF = DEF_NBF_COEF,
  parameter logic [OS*NBAUD*NBT_COEF-1:0] COEFS = DEF_RRC_COEFS,
  parameter int     NBT_OUT  = DEF_NBT_OUT,
  parameter int     NBF_OUT  = DEF_NBF_OUT,
  parameter prbs9_t SEED_I   = 9'h1AA,
  parameter prbs9_t SEED_Q   = 9'h1FE
) (
  input  logic               clk,
  input  logic               i_reset,
  tx_pulse_shaper_if.master  bus
);

  localparam int NB_PH  = (OS > 1) ? $clog2(OS) : 1;
  localparam int NB_ACC = NBT_COEF + $clog2(NBAUD) + 1;
  localparam int SHIFT  = NBF_COEF - NBF_OUT;

  localparam logic [NB_PH-1:0]         PH_LAST = NB_PH'(OS - 1);
  localparam logic [NB_PH-1:0]         PH_ZERO = '0;
  localparam logic signed [NB_ACC-1:0] OUT_MAX = NB_ACC'((2 ** (NBT_OUT - 1)) - 1);
  localparam logic signed [NB_ACC-1:0] OUT_MIN = ~OUT_MAX;

  if (OS < 2) begin : g_os_check
    $error("tx_pulse_shaper: OS must be at least 2");
  end
  if (NBF_OUT > NBF_COEF) begin : g_frac_check
    $error("tx_pulse_shaper: NBF_OUT must not exceed NBF_COEF");
  end

  logic [NB_PH-1:0]          ph;
  logic                      sym_adv;
  logic                      prbs_bit_i;
  logic                      prbs_bit_q;
  logic [NBAUD-1:0]          sym_i;
  logic [NBAUD-1:0]          sym_q;
  logic signed [NB_ACC-1:0]  acc_i;
  logic signed [NB_ACC-1:0]  acc_q;
  logic signed [NBT_OUT-1:0] smp_i;
  logic signed [NBT_OUT-1:0] smp_q;

  // Symbol boundary: last phase of an enabled symbol period.
  assign sym_adv = bus.i_en_tx && (ph == PH_LAST);

  // Polyphase branch for phase p: symbol slot k meets tap k*OS+p.
  // Each symbol is +/-1, so the product collapses into an add or a subtract.
  // Coefficients are sign-extended before negation so the most-negative tap negates cleanly.
  function automatic logic signed [NB_ACC-1:0] tap_sum(
    input logic [NBAUD-1:0] syms,
    input logic [NB_PH-1:0] p
  );
    logic signed [NBT_COEF-1:0] cn;
    logic signed [NB_ACC-1:0]   c;
    logic signed [NB_ACC-1:0]   acc;
    acc = '0;
    for (int k = 0; k < NBAUD; k++) begin
      cn  = COEFS[(k * OS + int'(p)) * NBT_COEF +: NBT_COEF];
      c   = {{(NB_ACC - NBT_COEF){cn[NBT_COEF-1]}}, cn};
      acc = (syms[k] == SYM_BIT_NEG) ? (acc - c) : (acc + c);
    end
    tap_sum = acc;
  endfunction

  // Drop the extra fraction bits (arithmetic shift = floor) and clamp to the output range.
  function automatic logic signed [NBT_OUT-1:0] sat_out(input logic signed [NB_ACC-1:0] acc);
    logic signed [NB_ACC-1:0] sh;
    sh = acc >>> SHIFT;
    if (sh > OUT_MAX) begin
      sat_out = OUT_MAX[NBT_OUT-1:0];
    end else if (sh < OUT_MIN) begin
      sat_out = OUT_MIN[NBT_OUT-1:0];
    end else begin
      sat_out = sh[NBT_OUT-1:0];
    end
  endfunction

  // Independent bit sources for the two rails, stepped once per symbol.
  tx_pulse_shaper_prbs9_gen #(.SEED(SEED_I)) u_prbs_i (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (sym_adv),
    .o_bit   (prbs_bit_i)
  );

  tx_pulse_shaper_prbs9_gen #(.SEED(SEED_Q)) u_prbs_q (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (sym_adv),
    .o_bit   (prbs_bit_q)
  );

  // Phase counter: wraps OS-1 -> 0 on each enabled cycle.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      ph <= PH_ZERO;
    end else if (bus.i_en_tx) begin
      ph <= (ph == PH_LAST) ? PH_ZERO : ph + NB_PH'(1);
    end
  end

  // Symbol delay lines: reset to all +1, newest PRBS bit enters slot 0 at the symbol boundary,
  // so a new symbol is first used by the following phase-0 sample.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      sym_i <= '0;
      sym_q <= '0;
    end else if (sym_adv) begin
      sym_i <= {sym_i[NBAUD-2:0], prbs_bit_i};
      sym_q <= {sym_q[NBAUD-2:0], prbs_bit_q};
    end
  end

  // Two add/sub trees for the current phase, then scaling and clamping.
  always_comb begin
    acc_i = tap_sum(sym_i, ph);
    acc_q = tap_sum(sym_q, ph);
    smp_i = sat_out(acc_i);
    smp_q = sat_out(acc_q);
  end

  // Output registers: sample, its phase, strobe and the newest slot bit all describe the same sample.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      bus.o_os_data_I  <= '0;
      bus.o_os_data_Q  <= '0;
      bus.o_bit_I      <= 1'b0;
      bus.o_bit_Q      <= 1'b0;
      bus.o_sym_strobe <= 1'b0;
      bus.o_phase      <= '0;
    end else if (bus.i_en_tx) begin
      bus.o_os_data_I  <= smp_i;
      bus.o_os_data_Q  <= smp_q;
      bus.o_bit_I      <= sym_i[0];
      bus.o_bit_Q      <= sym_q[0];
      bus.o_sym_strobe <= (ph == PH_ZERO);
      bus.o_phase      <= ph;
    end
  end

endmodule

// File: tb/tb_tx_pulse_shaper.sv
// Bench for tx_pulse_shaper: three instances (default RRC, single tap, saturating taps) under shared control.
// Latency: expected sample per edge is queued at stimulus time, popped and compared on the following falling edge.
// Backpressure: random and directed enable gaps, plus resets with enable held high.
module tb_tx_pulse_shaper;

  localparam int OS       = 4;
  localparam int NBAUD    = 6;
  localparam int NTAPS    = OS * NBAUD;
  localparam int NSYM     = 1024;
  localparam int NBF_COEF = 7;
  localparam int NBF_OUT  = 7;
  localparam int OUT_MAX  = 127;
  localparam int OUT_MIN  = -128;

  localparam logic [191:0] COEFS_A = 192'hFFFF_0104_01FA_F3F7_0D31_5260_5231_0DF7_F3FA_0104_01FF_FF00;
  localparam logic [191:0] COEFS_B = 192'h40;
  localparam logic [191:0] COEFS_C = {24{8'h7F}};
  localparam logic [8:0]   SEED_I_A = 9'h1AA;
  localparam logic [8:0]   SEED_Q_A = 9'h1FE;
  localparam logic [8:0]   SEED_I_C = 9'h1FF;

  logic clk;
  logic rst_n;

  tx_pulse_shaper_if #(.OS(OS), .NBT_OUT(8)) bus_a ();
  tx_pulse_shaper_if #(.OS(OS), .NBT_OUT(8)) bus_b ();
  tx_pulse_shaper_if #(.OS(OS), .NBT_OUT(8)) bus_c ();

  tx_pulse_shaper #(
    .OS(OS), .NBAUD(NBAUD), .NBT_COEF(8), .NBF_COEF(NBF_COEF), .COEFS(COEFS_A),
    .NBT_OUT(8), .NBF_OUT(NBF_OUT), .SEED_I(SEED_I_A), .SEED_Q(SEED_Q_A)
  ) dut_a (.clk(clk), .i_reset(rst_n), .bus(bus_a.master));

  tx_pulse_shaper #(
    .OS(OS), .NBAUD(NBAUD), .NBT_COEF(8), .NBF_COEF(NBF_COEF), .COEFS(COEFS_B),
    .NBT_OUT(8), .NBF_OUT(NBF_OUT), .SEED_I(SEED_I_A), .SEED_Q(SEED_Q_A)
  ) dut_b (.clk(clk), .i_reset(rst_n), .bus(bus_b.master));

  tx_pulse_shaper #(
    .OS(OS), .NBAUD(NBAUD), .NBT_COEF(8), .NBF_COEF(NBF_COEF), .COEFS(COEFS_C),
    .NBT_OUT(8), .NBF_OUT(NBF_OUT), .SEED_I(SEED_I_C), .SEED_Q(SEED_Q_A)
  ) dut_c (.clk(clk), .i_reset(rst_n), .bus(bus_c.master));

  typedef struct {
    int di;
    int dq;
    bit bi;
    bit bq;
    bit stb;
    int ph;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t last [3];

  int coef [3][NTAPS];
  bit bits [3][2][NSYM];
  int nvec = 0;
  int nmis = 0;
  int j    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference data: signed taps and the PRBS bit sequence (bit 0 = seed MSB) per instance and rail.
  task automatic init_model(input int d, input logic [191:0] cv, input logic [8:0] si, input logic [8:0] sq);
    logic signed [7:0] c8;
    int r;
    for (int n = 0; n < NTAPS; n++) begin
      c8 = cv[n*8 +: 8];
      coef[d][n] = int'(c8);
    end
    for (int b = 0; b < 2; b++) begin
      r = (b == 0) ? int'(si) : int'(sq);
      for (int m = 0; m < NSYM; m++) begin
        bits[d][b][m] = ((r >> 8) & 1) != 0;
        r = ((r << 1) & 511) | (((r >> 8) ^ (r >> 4)) & 1);
      end
    end
  endtask

  // Sample jj after reset: phase p = jj mod OS, slot k holds symbol (jj/OS - 1 - k); before the
  // first symbol the slots carry +1.
  function automatic exp_t model(input int d, input int jj);
    exp_t e;
    int p, m, acc, idx;
    p = jj % OS;
    m = jj / OS;
    e = '{default: 0};
    for (int b = 0; b < 2; b++) begin
      acc = 0;
      for (int k = 0; k < NBAUD; k++) begin
        idx = m - 1 - k;
        if (idx >= 0 && bits[d][b][idx]) acc -= coef[d][k*OS + p];
        else acc += coef[d][k*OS + p];
      end
      acc = acc >>> (NBF_COEF - NBF_OUT);
      if (acc > OUT_MAX) acc = OUT_MAX;
      if (acc < OUT_MIN) acc = OUT_MIN;
      if (b == 0) e.di = acc;
      else e.dq = acc;
    end
    e.bi  = (m >= 1) ? bits[d][0][m-1] : 1'b0;
    e.bq  = (m >= 1) ? bits[d][1][m-1] : 1'b0;
    e.stb = (p == 0);
    e.ph  = p;
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input int di, input int dq,
                     input logic bi, input logic bq, input logic stb, input int ph);
    nvec++;
    if (di !== e.di || dq !== e.dq || bi !== e.bi || bq !== e.bq || stb !== e.stb || ph !== e.ph) begin
      nmis++;
      $display("FAIL %s sample @%0t: got I=%0d Q=%0d bI=%0b bQ=%0b stb=%0b ph=%0d, want I=%0d Q=%0d bI=%0b bQ=%0b stb=%0b ph=%0d",
               nm, $time, di, dq, bi, bq, stb, ph, e.di, e.dq, e.bi, e.bq, e.stb, e.ph);
    end
  endtask

  // Apply one edge's worth of control and queue what each instance must show after that edge.
  task automatic cycle(input bit r, input bit en);
    rst_n         = r;
    bus_a.i_en_tx = en;
    bus_b.i_en_tx = en;
    bus_c.i_en_tx = en;
    if (!r) begin
      j = 0;
      for (int d = 0; d < 3; d++) last[d] = '{default: 0};
    end else if (en) begin
      for (int d = 0; d < 3; d++) last[d] = model(d, j);
      j++;
    end
    q_a.push_back(last[0]);
    q_b.push_back(last[1]);
    q_c.push_back(last[2]);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one queued expectation per instance per edge, checked on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      cmp("rrc", e, int'(bus_a.o_os_data_I), int'(bus_a.o_os_data_Q), bus_a.o_bit_I, bus_a.o_bit_Q,
          bus_a.o_sym_strobe, int'(bus_a.o_phase));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      cmp("single_tap", e, int'(bus_b.o_os_data_I), int'(bus_b.o_os_data_Q), bus_b.o_bit_I, bus_b.o_bit_Q,
          bus_b.o_sym_strobe, int'(bus_b.o_phase));
    end
    if (q_c.size() > 0) begin
      e = q_c.pop_front();
      cmp("saturate", e, int'(bus_c.o_os_data_I), int'(bus_c.o_os_data_Q), bus_c.o_bit_I, bus_c.o_bit_Q,
          bus_c.o_sym_strobe, int'(bus_c.o_phase));
    end
  end

  initial begin
    init_model(0, COEFS_A, SEED_I_A, SEED_Q_A);
    init_model(1, COEFS_B, SEED_I_A, SEED_Q_A);
    init_model(2, COEFS_C, SEED_I_C, SEED_Q_A);

    // Reset with enable both high and low: reset must win.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Long run past one full PRBS period with sparse random enable gaps.
    for (int i = 0; i < 2200; i++) cycle(1'b1, $urandom_range(0, 15) != 0);

    // Hold enable low for 5 cycles while the internal phase is 2.
    while (j % OS != 2) cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);

    // One-cycle reset in the middle of a symbol, then the stream must restart from scratch.
    while (j % OS != 1) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 200; i++) cycle(1'b1, $urandom_range(0, 7) != 0);

    @(negedge clk);
    #1;
    nvec++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_a.size() + q_b.size() + q_c.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
